// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that drains into the UART transmitter
//
// Purpose:
//   Producers push bytes in bursts. A three-state drain FSM hands one byte
//   at a time to the serial transmitter using the start_trigger / tx_data /
//   tx_busy handshake.
//
// Parameters:
//   DEPTH   number of byte entries (power of 2, minimum 2)
//   ADDR_W  log2(DEPTH), read/write pointer width
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   push           write request; push_data is sampled on the same edge
//   push_data[7:0] byte to enqueue
//   full           count == DEPTH
//   empty          count == 0
//   count          occupied entries, 0..DEPTH
//   start_trigger  registered one-cycle launch pulse to the transmitter
//   tx_data[7:0]   registered byte for the transmitter, held until next launch
//   tx_busy        transmitter busy flag
//
// Optional feature (macro UART_TX_FIFO_OVF_EN):
//   ovf_clr        clears the sticky overflow flag
//   overflow       sticky flag, set by a push while full (set beats clear)

module uart_tx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [7:0]        push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              start_trigger,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    input  logic              ovf_clr,
    output logic              overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    state_t              state_q, state_d;
    logic                start_trigger_q, start_trigger_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [7:0]          mem_q [DEPTH];
    logic [7:0]          mem_d [DEPTH];

    logic                push_ok;
    logic                launch;

`ifdef UART_TX_FIFO_OVF_EN
    logic                overflow_q, overflow_d;
`endif

    // Flags come straight from the count register so they carry no extra
    // latency relative to count itself.
    assign full          = (count_q == FULL_COUNT);
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign start_trigger = start_trigger_q;
    assign tx_data       = tx_data_q;

    // A push into a full FIFO is dropped even if a pop happens on the same
    // edge, so acceptance only looks at the registered full flag.
    assign push_ok = push && !full;

    // Launch samples the registered empty flag: a byte pushed on this edge
    // cannot be launched on the same edge.
    assign launch = (state_q == IDLE) && !empty && !tx_busy;

    // Storage and pointer next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end

        if (launch) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Simultaneous accepted push and pop leave count unchanged.
        if (push_ok && !launch) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && launch) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Drain FSM next-state and registered outputs.
    always_comb begin
        state_d         = state_q;
        start_trigger_d = 1'b0;
        tx_data_d       = tx_data_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    tx_data_d       = mem_q[rd_ptr_q];
                    start_trigger_d = 1'b1;
                    state_d         = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // start_trigger_d stays at its default 0 here, which makes
                // the launch pulse exactly one cycle long.
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Clear is applied first so that a coincident set wins.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (push && full) begin
            overflow_d = 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            start_trigger_q <= 1'b0;
            tx_data_q       <= 8'h00;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
`ifdef UART_TX_FIFO_OVF_EN
            overflow_q      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            start_trigger_q <= start_trigger_d;
            tx_data_q       <= tx_data_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
`ifdef UART_TX_FIFO_OVF_EN
            overflow_q      <= overflow_d;
`endif
        end
    end

    // Stored bytes are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        = 1'b1;
    logic        push       = 1'b0;
    logic [7:0]  push_data  = 8'h00;
    logic        busy_force = 1'b0;
    logic        tx_busy;
    logic        full;
    logic        empty;
    logic [ADDR_W:0] count;
    logic        start_trigger;
    logic [7:0]  tx_data;
    logic        ovf_clr    = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    logic        overflow;
`endif

    // Transmitter model: busy rises the cycle after the pulse is sampled
    // and stays high for 'hold' cycles.
    int  busy_cnt = 0;
    bit  arm      = 1'b0;
    bit  xmit_en  = 1'b0;
    int  hold     = 20;

    assign tx_busy = busy_force | (busy_cnt > 0);

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_data    (push_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .start_trigger(start_trigger),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf_clr      (ovf_clr),
        .overflow     (overflow)
`endif
    );

    int passes = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (busy_cnt > 0) busy_cnt--;
        if (arm) begin
            busy_cnt = hold;
            arm      = 1'b0;
        end
        if (start_trigger === 1'b1 && xmit_en) arm = 1'b1;
    end

    // Reference model: a byte queue plus the drain rules as stated.
    // phase: 0 = idle, 1 = waiting for busy, 2 = waiting for done.
    byte unsigned mq[$];
    int          phase   = 0;
    logic        exp_st  = 1'b0;
    logic [7:0]  exp_data = 8'h00;
    logic        exp_ovf = 1'b0;

    always @(posedge clk) begin
        bit do_launch;
        bit was_full;
        if (rst) begin
            mq.delete();
            phase    = 0;
            exp_st   = 1'b0;
            exp_data = 8'h00;
            exp_ovf  = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            do_launch = (phase == 0) && (mq.size() > 0) && !tx_busy;
            case (phase)
                0: if (do_launch) phase = 1;
                1: if (tx_busy) phase = 2;
                default: if (!tx_busy) phase = 0;
            endcase
            exp_st = do_launch;
            if (do_launch) exp_data = mq.pop_front();
            if (push && !was_full) mq.push_back(push_data);
            if (push && was_full) exp_ovf = 1'b1;
            else if (ovf_clr) exp_ovf = 1'b0;
        end
    end

    // Continuous comparison against the model plus a launch log.
    bit          chk_en = 1'b0;
    int          cyc    = 0;
    byte unsigned log_d[$];
    int          log_t[$];

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_empty", 32'(empty), 32'(mq.size() == 0));
            chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
            chk("m_start", 32'(start_trigger), 32'(exp_st));
            chk("m_tx_data", 32'(tx_data), 32'(exp_data));
`ifdef UART_TX_FIFO_OVF_EN
            chk("m_overflow", 32'(overflow), 32'(exp_ovf));
`endif
        end
        if (start_trigger === 1'b1) begin
            log_d.push_back(tx_data);
            log_t.push_back(cyc);
        end
    end

    typedef struct {
        bit         r;
        bit         p;
        logic [7:0] d;
        bit         b;
        int         cnt;
        bit         emp;
        bit         ful;
        bit         st;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[13];

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (mq.size() == 0 && phase == 0 && busy_cnt == 0 && !arm && !busy_force) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_wait", 32'(ok), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (log_d.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("log_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        //            r  p  d      b  cnt emp ful st data
        tbl[0]  = '{1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00};
        tbl[1]  = '{0, 1, 8'h41, 0, 1, 0, 0, 0, 8'h00};
        tbl[2]  = '{0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h41};
        tbl[3]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h41};
        tbl[4]  = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h41};
        tbl[5]  = '{0, 1, 8'h42, 1, 1, 0, 0, 0, 8'h41};
        tbl[6]  = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h41};
        tbl[7]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h41};
        tbl[8]  = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h41};
        tbl[9]  = '{0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h42};
        tbl[10] = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h42};
        tbl[11] = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h42};
        tbl[12] = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h42};

        for (int i = 0; i < 13; i++) begin
            rst        = tbl[i].r;
            push       = tbl[i].p;
            push_data  = tbl[i].d;
            busy_force = tbl[i].b;
            @(negedge clk);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].ful));
            chk($sformatf("v%0d_start", i), 32'(start_trigger), 32'(tbl[i].st));
            chk($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].data));
            chk_en = 1'b1;
        end
        rst = 1'b0; push = 1'b0; busy_force = 1'b0;

        // Fill to full with the transmitter held busy, then overflow.
        busy_force = 1'b1;
        xmit_en    = 1'b1;
        hold       = 20;
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; push_data = 8'(8'h30 + i);
            @(negedge clk);
        end
        push = 1'b0;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        push = 1'b1; push_data = 8'hFF;
        @(negedge clk);
        push = 1'b0;
        chk("ovf_count", 32'(count), 32'd8);
`ifdef UART_TX_FIFO_OVF_EN
        chk("ovf_set", 32'(overflow), 32'd1);
        @(negedge clk);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        push = 1'b1; push_data = 8'hFF; ovf_clr = 1'b1;
        @(negedge clk);
        push = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr2", 32'(overflow), 32'd0);
`endif
        log_d.delete(); log_t.delete();
        busy_force = 1'b0;
        wait_log(8, 400);
        chk("burst_n", 32'(log_d.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_d.size(); i++) begin
            chk($sformatf("burst_byte%0d", i), 32'(log_d[i]), 32'(8'h30 + i));
            if (i > 0) chk($sformatf("burst_gap%0d", i), 32'(log_t[i] - log_t[i-1] >= 23), 32'd1);
        end

        // Pointer wrap with a push on the launch edge at count 3.
        wait_idle();
        hold = 4;
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_data = 8'(8'hA0 + i);
            @(negedge clk);
        end
        push = 1'b0; busy_force = 1'b0;
        wait_idle();
        busy_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_data = 8'(8'h50 + i);
            @(negedge clk);
        end
        chk("wrap_pre_count", 32'(count), 32'd3);
        log_d.delete(); log_t.delete();
        busy_force = 1'b0; push = 1'b1; push_data = 8'h53;
        @(negedge clk);
        chk("wrap_same_edge_count", 32'(count), 32'd3);
        chk("wrap_start", 32'(start_trigger), 32'd1);
        chk("wrap_tx_data", 32'(tx_data), 32'h50);
        push_data = 8'h54;
        @(negedge clk);
        push = 1'b0;
        chk("wrap_count4", 32'(count), 32'd4);
        wait_log(5, 200);
        for (int i = 0; i < 5 && i < log_d.size(); i++)
            chk($sformatf("wrap_byte%0d", i), 32'(log_d[i]), 32'(8'h50 + i));

        // Reset while waiting for the frame to finish, 4 bytes queued.
        wait_idle();
        hold = 20;
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_data = 8'(8'h60 + i);
            @(negedge clk);
        end
        push = 1'b0;
        chk("rst_pre_count", 32'(count), 32'd4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_start", 32'(start_trigger), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        log_d.delete(); log_t.delete();
        repeat (40) @(negedge clk);
        chk("rst_no_pulse", 32'(log_d.size()), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            push       = ($urandom_range(0, 9) < 4);
            push_data  = 8'($urandom);
            busy_force = ($urandom_range(0, 19) == 0);
            ovf_clr    = ($urandom_range(0, 9) == 0);
            hold       = $urandom_range(1, 6);
            @(negedge clk);
        end
        rst = 1'b0; push = 1'b0; busy_force = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
